// File: rtl/ib_align_writer.sv
// Aligned-stream writer: turns one control word (byte address + length) and a
// framed 64-bit stream into word writes with byte enables and DONE/ERROR pulses.
module ib_align_writer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] CTRL_ADDR,
  input  logic [11:0] CTRL_LEN,
  input  logic        CTRL_SRC_RDY,
  output logic        CTRL_DST_RDY,
  input  logic [63:0] IN_DATA,
  input  logic        IN_SOF,
  input  logic        IN_EOF,
  input  logic        IN_SRC_RDY,
  output logic        IN_DST_RDY,
  output logic [28:0] WR_ADDR,
  output logic [63:0] WR_DATA,
  output logic [7:0]  WR_BE,
  output logic        WR_REQ,
  input  logic        WR_RDY,
  output logic        DONE,
  output logic        ERROR,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on any rising edge where the source's
  // *_SRC_RDY / WR_REQ and the sink's *_DST_RDY / WR_RDY are both high.
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DROP = 2'd2} state_t;

  state_t      state;
  logic [28:0] base;
  logic [2:0]  off;
  logic [2:0]  end_b;
  logic [9:0]  last_idx;
  logic [9:0]  cnt;
  logic        sof_err;

  logic [12:0] len_ext;
  logic [12:0] last_byte;
  logic        is_first;
  logic        is_last;
  logic        accept;
  logic        sof_bad;
  logic [7:0]  be_first;
  logic [7:0]  be_last;

  // Offset of the final byte relative to the first word; 4102 at most.
  assign len_ext   = (CTRL_LEN == 12'd0) ? 13'd4096 : {1'b0, CTRL_LEN};
  assign last_byte = {10'd0, CTRL_ADDR[2:0]} + len_ext - 13'd1;

  assign is_first = (cnt == 10'd0);
  assign is_last  = (cnt == last_idx);
  assign accept   = (state == XFER) && IN_SRC_RDY && WR_RDY;
  assign sof_bad  = (IN_SOF != is_first);

  assign be_first = 8'hFF << off;
  assign be_last  = 8'hFF >> (3'd7 - end_b);

  assign CTRL_DST_RDY = (state == IDLE);
  assign WR_REQ       = (state == XFER) && IN_SRC_RDY;
  assign IN_DST_RDY   = (state == XFER) ? WR_RDY : (state == DROP);
  assign WR_DATA      = IN_DATA;
  assign WR_ADDR      = base + {19'd0, cnt};
  assign dbg_state    = state;

  always_comb begin
    WR_BE = 8'hFF;
    if (is_first) WR_BE = WR_BE & be_first;
    if (is_last)  WR_BE = WR_BE & be_last;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      base     <= '0;
      off      <= '0;
      end_b    <= '0;
      last_idx <= '0;
      cnt      <= '0;
      sof_err  <= 1'b0;
      DONE     <= 1'b0;
      ERROR    <= 1'b0;
    end else begin
      DONE  <= 1'b0;
      ERROR <= 1'b0;
      case (state)
        IDLE: begin
          if (CTRL_SRC_RDY) begin
            base     <= CTRL_ADDR[31:3];
            off      <= CTRL_ADDR[2:0];
            end_b    <= last_byte[2:0];
            last_idx <= last_byte[12:3];
            cnt      <= '0;
            sof_err  <= 1'b0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            // Early EOF, missing EOF and misplaced SOF all share one pulse.
            if (sof_bad || (is_last != IN_EOF)) ERROR <= 1'b1;
            if (sof_bad) sof_err <= 1'b1;
            if (is_last) begin
              if (IN_EOF) begin
                DONE  <= !sof_bad && !sof_err;
                state <= IDLE;
              end else begin
                state <= DROP;
              end
            end else if (IN_EOF) begin
              state <= IDLE;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
        end
        DROP: begin
          if (IN_SRC_RDY && IN_EOF) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ib_align_writer.md
IB_ALIGN_WRITER -- requirements
Module: ib_align_writer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-002 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port CTRL_ADDR, input, 32 bits: destination byte address of the transfer.
REQ-004 SHALL have port CTRL_LEN, input, 12 bits: transfer length in bytes; 0 encodes 4096.
REQ-005 SHALL have ports CTRL_SRC_RDY (input, 1 bit) and CTRL_DST_RDY (output, 1 bit): control-word handshake.
REQ-006 SHALL have port IN_DATA, input, 64 bits: aligned data word from the align unit.
REQ-007 SHALL have ports IN_SOF and IN_EOF, inputs, 1 bit each: frame start and frame end markers.
REQ-008 SHALL have ports IN_SRC_RDY (input, 1 bit) and IN_DST_RDY (output, 1 bit): input stream handshake.
REQ-009 SHALL have port WR_ADDR, output, 29 bits: 64-bit-word address of the write.
REQ-010 SHALL have port WR_DATA, output, 64 bits: write data.
REQ-011 SHALL have port WR_BE, output, 8 bits: byte enables; bit i enables byte i (bits 8i+7:8i).
REQ-012 SHALL have ports WR_REQ (output, 1 bit) and WR_RDY (input, 1 bit): write handshake; a write occurs on a cycle with both high.
REQ-013 SHALL have ports DONE and ERROR, outputs, 1 bit each: single-cycle status pulses.

Function
REQ-014 SHALL implement FSM states IDLE, XFER and DROP.
REQ-015 SHALL drive CTRL_DST_RDY=1 only in IDLE; CTRL_SRC_RDY=1 in IDLE captures CTRL_ADDR and CTRL_LEN and moves to XFER on the next cycle.
REQ-016 SHALL compute, using 13-bit arithmetic, L = (CTRL_LEN==0 ? 4096 : CTRL_LEN), off = CTRL_ADDR[2:0], end = (off+L-1) mod 8, and WORDS = ((off+L-1)>>3)+1 (range 1..513).
REQ-017 SHALL, in XFER, drive WR_REQ=IN_SRC_RDY, IN_DST_RDY=WR_RDY and WR_DATA=IN_DATA combinationally (zero latency); a word is accepted when IN_SRC_RDY=1 and WR_RDY=1.
REQ-018 SHALL set WR_ADDR = CTRL_ADDR[31:3] + k for the k-th accepted word (k from 0), wrapping modulo 2^29.
REQ-019 SHALL set WR_BE on the first word to bits off..7 set, on the last word to bits 0..end set, on a single-word transfer to the AND of both, and on middle words to 0xFF.
REQ-020 SHALL expect IN_SOF=1 only on word 0 and IN_EOF=1 only on word WORDS-1.
REQ-021 SHALL, on an accepted word with IN_EOF=1 before the last word: write that word, pulse ERROR on the next cycle, and return to IDLE without DONE.
REQ-022 SHALL, on an accepted last word with IN_EOF=0: write that word, pulse ERROR, and enter DROP.
REQ-023 SHALL, on an SOF mismatch: pulse ERROR, continue the transfer, and suppress DONE.
REQ-024 SHALL, in DROP: drive WR_REQ=0 and IN_DST_RDY=1, and discard words until an accepted IN_EOF=1, then go to IDLE.
REQ-025 SHALL, after an error-free last word, pulse DONE on the next cycle and return to IDLE.
REQ-026 SHALL drive WR_REQ=0 and IN_DST_RDY=0 in IDLE; ERROR and DONE are registered and never high in the same cycle.

Reset
REQ-027 SHALL, on RESET=0, immediately clear the FSM to IDLE, the word counter to 0, and DONE, ERROR, WR_REQ and IN_DST_RDY to 0, with CTRL_DST_RDY=1 after release.
REQ-028 SHALL abandon a transfer in progress at reset without any further write, DONE or ERROR.

Verification
REQ-029 SHALL cover: ADDR=0x1003, LEN=10 -> two writes, WR_ADDR 0x200/0x201, WR_BE 0xF8/0x1F, SOF/EOF on words 0/1, DONE once.
REQ-030 SHALL cover: ADDR=0x5, LEN=2, one word with SOF+EOF -> one write, WR_BE=0x60, DONE.
REQ-031 SHALL cover: ADDR=0x0, LEN=0 -> 512 writes, all WR_BE=0xFF, WR_ADDR 0..511, DONE once.
REQ-032 SHALL cover: ADDR=0x0, LEN=24 with WR_RDY and IN_SRC_RDY randomly toggled -> exactly 3 writes in order, none duplicated or lost.
REQ-033 SHALL cover: LEN=24 with EOF on word 1 -> 2 writes, ERROR pulse, no DONE; then LEN=8 without EOF followed by two extra words ending in EOF -> 1 write, ERROR, extra words consumed with WR_REQ=0.
REQ-034 SHALL cover: RESET asserted after word 1 of 4 -> outputs at reset values at once; a new transfer after release completes normally.
